// File: rtl/bus_dma_arbiter_pkg.sv
// Shared definitions for the CPU/DMA bus arbiter: register word offsets,
// CTRL bit positions, stride codes, FSM state encoding and a stride decode.
package bus_dma_arbiter_pkg;

    // Word offsets inside the 16-byte register window (addr[3:2])
    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    // CTRL bit positions
    localparam int CTRL_START  = 0;
    localparam int CTRL_DONE   = 1;
    localparam int CTRL_STR_LO = 2;
    localparam int CTRL_STR_HI = 3;
    localparam int CTRL_IE     = 4;

    // Destination stride codes
    localparam logic [1:0] STRIDE_1  = 2'd0;
    localparam logic [1:0] STRIDE_2  = 2'd1;
    localparam logic [1:0] STRIDE_4  = 2'd2;
    localparam logic [1:0] STRIDE_4X = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    function automatic logic [31:0] stride_bytes(input logic [1:0] code);
        logic [31:0] step;
        unique case (code)
            STRIDE_1: step = 32'd1;
            STRIDE_2: step = 32'd2;
            default:  step = 32'd4;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/bus_dma_arbiter_regfile.sv
// DMA register window: address decode, SRC/DST/LEN/CTRL storage, done W1C,
// and the combinational read mux. Optional interrupt enable under DMA_IRQ_EN.
// Ports: word_addr/wdata/wenable from CPU, busy/fin/fin_* from the FSM,
//        hit/rdata to the CPU path, start_go/src/dst/len/stride/irq to the top.
module bus_dma_arbiter_regfile
    import bus_dma_arbiter_pkg::*;
#(
    parameter logic [31:0] REG_BASE = 32'hF000_1000,
    parameter int          LEN_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [29:0]      word_addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wenable,
    input  logic             busy,
    input  logic             fin,
    input  logic [31:0]      fin_src,
    input  logic [31:0]      fin_dst,
    output logic             hit,
    output logic [31:0]      rdata,
    output logic             start_go,
    output logic [31:0]      src,
    output logic [31:0]      dst,
    output logic [LEN_W-1:0] len,
    output logic [1:0]       stride,
    output logic             irq
);

    logic       done;
    logic       ie;
    logic [1:0] offset;
    logic       wr;
    logic       wr_src;
    logic       wr_dst;
    logic       wr_len;
    logic       wr_ctrl;
    logic       start_wr;
    logic       set_done;
    logic       clr_done;

    assign hit    = (word_addr[29:2] == REG_BASE[31:4]);
    assign offset = word_addr[1:0];

    // Partial-word writes and writes while the engine runs are dropped
    assign wr      = hit & ~busy & (&wenable);
    assign wr_src  = wr & (offset == REG_SRC);
    assign wr_dst  = wr & (offset == REG_DST);
    assign wr_len  = wr & (offset == REG_LEN);
    assign wr_ctrl = wr & (offset == REG_CTRL);

    assign start_wr = wr_ctrl & wdata[CTRL_START];
    assign start_go = start_wr & (len != '0);

    // Clear applies before set so a combined W1C+start ends with done set
    assign clr_done = wr_ctrl & wdata[CTRL_DONE];
    assign set_done = fin | (start_wr & (len == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src    <= '0;
            dst    <= '0;
            len    <= '0;
            stride <= STRIDE_1;
            done   <= 1'b0;
        end else begin
            if (fin) begin
                src <= fin_src;
                dst <= fin_dst;
                len <= '0;
            end else begin
                if (wr_src) src <= {wdata[31:2], 2'b00};
                if (wr_dst) dst <= wdata;
                if (wr_len) len <= wdata[LEN_W-1:0];
            end
            if (wr_ctrl) stride <= wdata[CTRL_STR_HI:CTRL_STR_LO];
            done <= set_done | (done & ~clr_done);
        end
    end

`ifdef DMA_IRQ_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ie <= 1'b0;
        end else if (wr_ctrl) begin
            ie <= wdata[CTRL_IE];
        end
    end

    assign irq = done & ie;
`else
    assign ie  = 1'b0;
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        unique case (offset)
            REG_SRC:  rdata = src;
            REG_DST:  rdata = dst;
            REG_LEN:  rdata[LEN_W-1:0] = len;
            REG_CTRL: rdata = {27'd0, ie, stride, done, busy};
        endcase
    end

endmodule

// File: rtl/bus_dma_arbiter.sv
// Shares the SoC data bus between the CPU and a one-channel RAM-to-bus DMA.
// The CPU is stalled for 2*LEN+1 cycles while the engine copies words.
// Ports: cpu_* (CPU data port), bus_* (to decode/rdata mux), irq_done.
// Build option: define DMA_IRQ_EN to enable irq_done = done & ie.
module bus_dma_arbiter
    import bus_dma_arbiter_pkg::*;
#(
    parameter logic [31:0] REG_BASE = 32'hF000_1000,
    parameter int          LEN_W    = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wenable,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wenable,
    input  logic [31:0] bus_rdata,
    output logic        irq_done
);

    state_t           state;
    state_t           state_next;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] cnt_q;

    logic             hit;
    logic [31:0]      reg_rdata;
    logic             start_go;
    logic [31:0]      reg_src;
    logic [31:0]      reg_dst;
    logic [LEN_W-1:0] reg_len;
    logic [1:0]       reg_stride;
    logic             busy;
    logic             fin;

    assign busy = (state != ST_IDLE);
    assign fin  = (state == ST_FIN);

    bus_dma_arbiter_regfile #(
        .REG_BASE (REG_BASE),
        .LEN_W    (LEN_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .word_addr (cpu_addr[31:2]),
        .wdata     (cpu_wdata),
        .wenable   (cpu_wenable),
        .busy      (busy),
        .fin       (fin),
        .fin_src   (src_q),
        .fin_dst   (dst_q),
        .hit       (hit),
        .rdata     (reg_rdata),
        .start_go  (start_go),
        .src       (reg_src),
        .dst       (reg_dst),
        .len       (reg_len),
        .stride    (reg_stride),
        .irq       (irq_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start_go) state_next = ST_RD;
            ST_RD:   state_next = ST_WR;
            ST_WR:   state_next = (cnt_q == LEN_W'(1)) ? ST_FIN : ST_RD;
            ST_FIN:  state_next = ST_IDLE;
        endcase
    end

    // Working pointers and word counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_q <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_go) begin
                        src_q <= {reg_src[31:2], 2'b00};
                        dst_q <= reg_dst;
                        cnt_q <= reg_len;
                    end
                end
                ST_WR: begin
                    src_q <= src_q + 32'd4;
                    dst_q <= dst_q + stride_bytes(reg_stride);
                    cnt_q <= cnt_q - LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Bus mux and stall
    always_comb begin
        bus_addr    = cpu_addr;
        bus_wdata   = cpu_wdata;
        bus_wenable = hit ? 4'b0000 : cpu_wenable;
        cpu_stall   = 1'b0;
        unique case (state)
            ST_IDLE: ;
            ST_RD: begin
                bus_addr    = src_q;
                bus_wenable = 4'b0000;
                cpu_stall   = 1'b1;
            end
            ST_WR: begin
                // RAM returns the word one cycle after the RD address
                bus_addr    = dst_q;
                bus_wdata   = bus_rdata;
                bus_wenable = 4'b1111;
                cpu_stall   = 1'b1;
            end
            ST_FIN: begin
                bus_addr    = src_q;
                bus_wenable = 4'b0000;
                cpu_stall   = 1'b1;
            end
        endcase
    end

    assign cpu_rdata = hit ? reg_rdata : bus_rdata;

endmodule

// File: tb/tb_bus_dma_arbiter.sv
// Scoreboard bench for bus_dma_arbiter: RAM model returns its own address,
// expected DMA bus writes are queued and checked by a negedge monitor.
module tb_bus_dma_arbiter;

    localparam logic [31:0] BASE  = 32'hF000_1000;
    localparam logic [31:0] A_SRC = BASE + 32'h0;
    localparam logic [31:0] A_DST = BASE + 32'h4;
    localparam logic [31:0] A_LEN = BASE + 32'h8;
    localparam logic [31:0] A_CTL = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wenable;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wenable;
    logic [31:0] bus_rdata;
    logic        irq_done;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  stall_cnt = 0;
    bit  irq_seen = 1'b0;

    always #5 clk = ~clk;

    bus_dma_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_wenable (cpu_wenable),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_wenable (bus_wenable),
        .bus_rdata   (bus_rdata),
        .irq_done    (irq_done)
    );

    // RAM model: every word holds its own address, 1-cycle read latency
    always @(posedge clk) bus_rdata <= bus_addr;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected DMA writes whenever the engine drives the bus
    always @(negedge clk) begin
        wr_t e;
        if (irq_done) irq_seen = 1'b1;
        if (cpu_stall) stall_cnt++;
        if (cpu_stall && bus_wenable != 4'b0000) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, none expected",
                         bus_addr, bus_wdata);
            end else begin
                e = sb.pop_front();
                check("wr_addr", bus_addr, e.addr);
                check("wr_data", bus_wdata, e.data);
                check("wr_en", {28'd0, bus_wenable}, 32'hF);
            end
        end
    end

    task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] we);
        cpu_addr    = a;
        cpu_wdata   = d;
        cpu_wenable = we;
        @(posedge clk);
        #1;
        cpu_wenable = 4'b0000;
        cpu_addr    = 32'h0;
    endtask

    task automatic chk_reg(input string name, input logic [31:0] a,
                           input logic [31:0] exp);
        cpu_addr    = a;
        cpu_wenable = 4'b0000;
        #1;
        check(name, cpu_rdata, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic push_copy(input logic [31:0] s, input logic [31:0] d,
                             input int n, input int step);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = d + 32'(i * step);
            e.data = s + 32'(i * 4);
            sb.push_back(e);
        end
    endtask

    task automatic run_to_idle(input string name, input int len);
        for (int i = 0; i < 200; i++) begin
            if (!cpu_stall) break;
            @(posedge clk);
            #1;
        end
        check({name, "_idle"}, {31'd0, cpu_stall}, 32'd0);
        check({name, "_stall_cycles"}, stall_cnt, 2 * len + 1);
        check({name, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        cpu_addr    = 32'h0;
        cpu_wdata   = 32'h0;
        cpu_wenable = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_irq", {31'd0, irq_done}, 32'd0);
        chk_reg("rst_ctrl", A_CTL, 32'h0);
        chk_reg("rst_src", A_SRC, 32'h0);

        // Partial write into the window is ignored and never reaches the bus
        cpu_addr    = A_SRC;
        cpu_wdata   = 32'hDEAD_BEEF;
        cpu_wenable = 4'b0011;
        #1;
        check("part_bus_wen", {28'd0, bus_wenable}, 32'h0);
        @(posedge clk);
        #1;
        cpu_wenable = 4'b0000;
        chk_reg("part_src", A_SRC, 32'h0);

        // Outside the window the CPU passes straight through
        cpu_addr    = 32'h0000_1234;
        cpu_wdata   = 32'h5555_AAAA;
        cpu_wenable = 4'b0011;
        #1;
        check("pass_wen", {28'd0, bus_wenable}, 32'h3);
        check("pass_addr", bus_addr, 32'h0000_1234);
        check("pass_wdata", bus_wdata, 32'h5555_AAAA);
        @(posedge clk);
        #1;
        cpu_wenable = 4'b0000;

        // Copy 3 words, stride 4
        cpu_wr(A_SRC, 32'h0000_0100, 4'hF);
        cpu_wr(A_DST, 32'h5000_0000, 4'hF);
        cpu_wr(A_LEN, 32'd3, 4'hF);
        push_copy(32'h100, 32'h5000_0000, 3, 4);
        stall_cnt = 0;
        cpu_wr(A_CTL, 32'h09, 4'hF);
        check("t1_stall_on", {31'd0, cpu_stall}, 32'd1);
        run_to_idle("t1", 3);
        chk_reg("t1_ctrl", A_CTL, 32'h0A);
        chk_reg("t1_src", A_SRC, 32'h0000_010C);
        chk_reg("t1_dst", A_DST, 32'h5000_000C);
        chk_reg("t1_len", A_LEN, 32'h0);

        // LEN=0 start: done at once, no stall, no writes
        cpu_wr(A_CTL, 32'h02, 4'hF);
        chk_reg("t2_cleared", A_CTL, 32'h00);
        stall_cnt = 0;
        cpu_wr(A_CTL, 32'h01, 4'hF);
        check("t2_no_stall", {31'd0, cpu_stall}, 32'd0);
        chk_reg("t2_ctrl", A_CTL, 32'h02);
        repeat (3) @(posedge clk);
        #1;
        check("t2_stall_cnt", stall_cnt, 32'd0);

        // 16 words to palette, stride 2
        cpu_wr(A_SRC, 32'h0000_0200, 4'hF);
        cpu_wr(A_DST, 32'h8000_0000, 4'hF);
        cpu_wr(A_LEN, 32'd16, 4'hF);
        push_copy(32'h200, 32'h8000_0000, 16, 2);
        stall_cnt = 0;
        cpu_wr(A_CTL, 32'h07, 4'hF);
        run_to_idle("t3", 16);
        chk_reg("t3_dst", A_DST, 32'h8000_0020);
        chk_reg("t3_src", A_SRC, 32'h0000_0240);
        chk_reg("t3_ctrl", A_CTL, 32'h06);

        // Interrupt enable, stride 1, one word
        cpu_wr(A_SRC, 32'h0000_0300, 4'hF);
        cpu_wr(A_DST, 32'h4000_0000, 4'hF);
        cpu_wr(A_LEN, 32'd1, 4'hF);
        push_copy(32'h300, 32'h4000_0000, 1, 1);
        stall_cnt = 0;
        cpu_wr(A_CTL, 32'h13, 4'hF);
        run_to_idle("t4", 1);
`ifdef DMA_IRQ_EN
        check("t4_irq_set", {31'd0, irq_done}, 32'd1);
        chk_reg("t4_ctrl", A_CTL, 32'h12);
        cpu_wr(A_CTL, 32'h12, 4'hF);
        check("t4_irq_clr", {31'd0, irq_done}, 32'd0);
        chk_reg("t4_ctrl_clr", A_CTL, 32'h10);
`else
        check("t4_irq_off", {31'd0, irq_done}, 32'd0);
        chk_reg("t4_ctrl", A_CTL, 32'h02);
        cpu_wr(A_CTL, 32'h12, 4'hF);
        chk_reg("t4_ctrl_clr", A_CTL, 32'h00);
        check("t4_irq_never", {31'd0, irq_seen}, 32'd0);
`endif

        // Reset during the 2nd WR of a 4-word copy
        cpu_wr(A_SRC, 32'h0000_0400, 4'hF);
        cpu_wr(A_DST, 32'h6000_0000, 4'hF);
        cpu_wr(A_LEN, 32'd4, 4'hF);
        push_copy(32'h400, 32'h6000_0000, 2, 4);
        cpu_wr(A_CTL, 32'h0B, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        check("t5_in_wr", {28'd0, bus_wenable}, 32'hF);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t5_stall", {31'd0, cpu_stall}, 32'd0);
        check("t5_irq", {31'd0, irq_done}, 32'd0);
        chk_reg("t5_ctrl", A_CTL, 32'h0);
        chk_reg("t5_src", A_SRC, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        check("t5_sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
